// File: rtl/regfile_pkg.sv
// Shared defaults and write-port priority for the regfile_sb register file.
// Imported by the top and the busy-bit scoreboard.
package regfile_pkg;

    localparam int REGFILE_DW    = 8;
    localparam int REGFILE_NREGS = 8;

    typedef enum logic {
        WR_PORT_A = 1'b0,
        WR_PORT_B = 1'b1
    } wr_port_e;

    // Port that wins both storage and forwarding on a same-address dual write
    localparam wr_port_e WR_PRIORITY = WR_PORT_B;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets a register's bit, a write clears it,
// and a coincident issue and write leave the bit set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REGFILE_NREGS,
    parameter int ZERO_REG = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_addr,
    input  logic                        we_a,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr_a,
    input  logic                        we_b,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr_b,
    output logic [NUM_REGS-1:0]         busy
);

    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_s;
    logic [NUM_REGS-1:0] clr_s;
    logic [NUM_REGS-1:0] zero_mask_s;

    function automatic logic [NUM_REGS-1:0] dec(input logic [AW-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = {NUM_REGS{1'b0}};
        v[a] = 1'b1;
        return v;
    endfunction

    // Next busy vector: clear on write, then set on issue so set wins
    always_comb begin
        zero_mask_s = (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b0}}, 1'b1} : {NUM_REGS{1'b0}};
        set_s  = {NUM_REGS{issue_valid}} & dec(issue_addr);
        clr_s  = ({NUM_REGS{we_a}} & dec(wr_addr_a)) | ({NUM_REGS{we_b}} & dec(wr_addr_b));
        busy_d = ((busy_q & ~clr_s) | set_s) & ~zero_mask_s;
    end

    // Busy vector state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= {NUM_REGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, two-write register file with optional hardwired zero register,
// same-cycle write forwarding and a per-register busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DW,
    parameter int NUM_REGS = REGFILE_NREGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr1,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr2,
    output logic [DATA_W-1:0]           rd_data1,
    output logic [DATA_W-1:0]           rd_data2,
    output logic                        rd_busy1,
    output logic                        rd_busy2,
    input  logic                        we_a,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr_a,
    input  logic [DATA_W-1:0]           wr_data_a,
    input  logic                        we_b,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr_b,
    input  logic [DATA_W-1:0]           wr_data_b,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_addr,
    output logic                        wr_conflict
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_conflict_d;
    logic                wr_conflict_q;
    logic [NUM_REGS-1:0] busy_s;

    logic                hi_we_s;
    logic [AW-1:0]       hi_addr_s;
    logic [DATA_W-1:0]   hi_data_s;
    logic                lo_we_s;
    logic [AW-1:0]       lo_addr_s;
    logic [DATA_W-1:0]   lo_data_s;

    logic [AW-1:0]       ra_s    [2];
    logic [DATA_W-1:0]   rdata_s [2];
    logic                rbusy_s [2];

    function automatic logic addr_live(input logic [AW-1:0] a);
        return (ZERO_REG == 0) || (a != {AW{1'b0}});
    endfunction

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .we_a        (we_a),
        .wr_addr_a   (wr_addr_a),
        .we_b        (we_b),
        .wr_addr_b   (wr_addr_b),
        .busy        (busy_s)
    );

    // Order the two write ports by priority so the winner is applied last
    always_comb begin
        if (WR_PRIORITY == WR_PORT_B) begin
            hi_we_s = we_b;  hi_addr_s = wr_addr_b;  hi_data_s = wr_data_b;
            lo_we_s = we_a;  lo_addr_s = wr_addr_a;  lo_data_s = wr_data_a;
        end else begin
            hi_we_s = we_a;  hi_addr_s = wr_addr_a;  hi_data_s = wr_data_a;
            lo_we_s = we_b;  lo_addr_s = wr_addr_b;  lo_data_s = wr_data_b;
        end
    end

    // Next array contents and dual-write conflict detection
    always_comb begin
        regs_d = regs_q;
        regs_d[lo_addr_s] = (lo_we_s && addr_live(lo_addr_s)) ? lo_data_s : regs_d[lo_addr_s];
        regs_d[hi_addr_s] = (hi_we_s && addr_live(hi_addr_s)) ? hi_data_s : regs_d[hi_addr_s];
        wr_conflict_d = we_a && we_b && (wr_addr_a == wr_addr_b);
    end

    // Register array and conflict pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign ra_s[0] = rd_addr1;
    assign ra_s[1] = rd_addr2;

    // Read muxes: forwarding keeps working during reset since it bypasses the array
    always_comb begin : read_mux
        logic hit_lo;
        logic hit_hi;
        logic iss_hit;
        rdata_s[0] = {DATA_W{1'b0}};
        rdata_s[1] = {DATA_W{1'b0}};
        rbusy_s[0] = 1'b0;
        rbusy_s[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            hit_lo  = (BYPASS != 0) && lo_we_s && (lo_addr_s == ra_s[p]);
            hit_hi  = (BYPASS != 0) && hi_we_s && (hi_addr_s == ra_s[p]);
            iss_hit = issue_valid && (issue_addr == ra_s[p]);
            if (!addr_live(ra_s[p])) begin
                rdata_s[p] = {DATA_W{1'b0}};
            end else if (hit_hi) begin
                rdata_s[p] = hi_data_s;
            end else if (hit_lo) begin
                rdata_s[p] = lo_data_s;
            end else begin
                rdata_s[p] = regs_q[ra_s[p]];
            end
            rbusy_s[p] = busy_s[ra_s[p]] && !((hit_lo || hit_hi) && !iss_hit);
        end
    end

    assign rd_data1    = rdata_s[0];
    assign rd_data2    = rdata_s[1];
    assign rd_busy1    = rbusy_s[0];
    assign rd_busy2    = rbusy_s[1];
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build plus BYPASS=0 and ZERO_REG=0
// builds driven by the same stimulus, each checked against hand-computed values.
module tb_regfile_sb;

    logic       clk;
    logic       rst_n;
    logic [2:0] rd_addr1, rd_addr2;
    logic       we_a, we_b, issue_valid;
    logic [2:0] wr_addr_a, wr_addr_b, issue_addr;
    logic [7:0] wr_data_a, wr_data_b;

    logic [7:0] d_rd1, d_rd2, b_rd1, b_rd2, z_rd1, z_rd2;
    logic       d_bz1, d_bz2, b_bz1, b_bz2, z_bz1, z_bz2;
    logic       d_cf, b_cf, z_cf;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d_rd1), .rd_data2(d_rd2), .rd_busy1(d_bz1), .rd_busy2(d_bz2),
        .we_a(we_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .we_b(we_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .wr_conflict(d_cf)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_busy1(b_bz1), .rd_busy2(b_bz2),
        .we_a(we_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .we_b(we_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .wr_conflict(b_cf)
    );

    regfile_sb #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_rd1), .rd_data2(z_rd2), .rd_busy1(z_bz1), .rd_busy2(z_bz2),
        .we_a(we_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .we_b(we_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .wr_conflict(z_cf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        we_a = 1'b1; wr_addr_a = 3'd6; wr_data_a = 8'h77;
        we_b = 1'b0; wr_addr_b = 3'd0; wr_data_b = 8'h00;
        issue_valid = 1'b0; issue_addr = 3'd0;
        rd_addr1 = 3'd7; rd_addr2 = 3'd6;
        #1;
        chk8("rst_bypass", d_rd2, 8'h77);
        chk8("rst_nobypass", b_rd2, 8'h00);
        chk8("rst_rd1", d_rd1, 8'h00);
        chk1("rst_conflict", d_cf, 1'b0);
        chk1("rst_busy", d_bz1, 1'b0);
        #6;
        we_a = 1'b0;
        #1;
        chk8("rst_write_discarded", d_rd2, 8'h00);
        rst_n = 1'b1;
        we_b = 1'b1; wr_addr_b = 3'd6; wr_data_b = 8'h66;
        at_edge();
        we_b = 1'b0;
        #1;
        chk8("first_write_after_rst", b_rd2, 8'h66);

        we_a = 1'b1; wr_addr_a = 3'd1; wr_data_a = 8'h55; rd_addr1 = 3'd1;
        #1;
        chk8("wa_bypass", d_rd1, 8'h55);
        chk8("wa_nobypass_old", b_rd1, 8'h00);
        at_edge();
        we_a = 1'b0; we_b = 1'b1; wr_addr_b = 3'd2; wr_data_b = 8'hAA; rd_addr2 = 3'd2;
        #1;
        chk8("reg1_stored", b_rd1, 8'h55);
        chk8("wb_bypass", d_rd2, 8'hAA);
        chk8("wb_nobypass_old", b_rd2, 8'h00);
        at_edge();
        we_b = 1'b0;
        #1;
        chk8("reg2_stored", b_rd2, 8'hAA);
        chk8("reg1_dflt", d_rd1, 8'h55);

        we_a = 1'b1; wr_addr_a = 3'd0; wr_data_a = 8'hFF; rd_addr1 = 3'd0;
        #1;
        chk8("zero_bypass_blocked", d_rd1, 8'h00);
        chk8("nozero_bypass", z_rd1, 8'hFF);
        at_edge();
        we_a = 1'b0;
        #1;
        chk8("zero_stays_zero", d_rd1, 8'h00);
        chk8("nozero_stored", z_rd1, 8'hFF);

        we_a = 1'b1; wr_addr_a = 3'd3; wr_data_a = 8'h11;
        we_b = 1'b1; wr_addr_b = 3'd3; wr_data_b = 8'h22; rd_addr1 = 3'd3;
        #1;
        chk8("dual_bypass_b", d_rd1, 8'h22);
        chk8("dual_nobypass_old", b_rd1, 8'h00);
        chk1("conflict_pre", d_cf, 1'b0);
        at_edge();
        we_a = 1'b0; we_b = 1'b0;
        #1;
        chk1("conflict_pulse", d_cf, 1'b1);
        chk8("dual_stored_b", b_rd1, 8'h22);
        at_edge();
        chk1("conflict_cleared", d_cf, 1'b0);

        we_a = 1'b1; wr_addr_a = 3'd4; wr_data_a = 8'h3C; rd_addr1 = 3'd4;
        #1;
        chk8("bypass_same_cycle", d_rd1, 8'h3C);
        chk8("nobypass_same_cycle", b_rd1, 8'h00);
        at_edge();
        we_a = 1'b0;
        #1;
        chk8("nobypass_after_edge", b_rd1, 8'h3C);

        issue_valid = 1'b1; issue_addr = 3'd5; rd_addr1 = 3'd5;
        #1;
        chk1("busy_before_edge", d_bz1, 1'b0);
        at_edge();
        issue_valid = 1'b0;
        #1;
        chk1("busy_set", d_bz1, 1'b1);
        chk1("busy_set_nb", b_bz1, 1'b1);
        issue_valid = 1'b1; we_a = 1'b1; wr_addr_a = 3'd5; wr_data_a = 8'h99;
        #1;
        chk1("busy_issue_write_comb", d_bz1, 1'b1);
        at_edge();
        issue_valid = 1'b0; we_a = 1'b0;
        #1;
        chk1("busy_set_wins", d_bz1, 1'b1);
        chk8("reg5_written", d_rd1, 8'h99);
        we_b = 1'b1; wr_addr_b = 3'd5; wr_data_b = 8'h5A;
        #1;
        chk1("busy_masked_bypass", d_bz1, 1'b0);
        chk1("busy_unmasked_nb", b_bz1, 1'b1);
        at_edge();
        we_b = 1'b0;
        #1;
        chk1("busy_cleared", d_bz1, 1'b0);
        chk1("busy_cleared_nb", b_bz1, 1'b0);

        issue_valid = 1'b1; issue_addr = 3'd0;
        at_edge();
        issue_addr = 3'd7;
        at_edge();
        at_edge();
        issue_valid = 1'b0; rd_addr1 = 3'd7; rd_addr2 = 3'd0;
        #1;
        chk1("busy_reissue_top", d_bz1, 1'b1);
        chk1("busy_zero_ignored", d_bz2, 1'b0);
        chk1("busy_zero_nozero", z_bz2, 1'b1);

        for (int i = 1; i < 8; i++) begin
            we_a = 1'b1; wr_addr_a = 3'(i); wr_data_a = 8'h10 + 8'(i);
            at_edge();
        end
        we_a = 1'b0; issue_valid = 1'b1; issue_addr = 3'd3;
        at_edge();
        issue_valid = 1'b0; rd_addr1 = 3'd7; rd_addr2 = 3'd3;
        #1;
        chk8("fill_reg7", d_rd1, 8'h17);
        chk8("fill_reg3", d_rd2, 8'h13);
        chk1("busy3_before_rst", d_bz2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk8("arst_reg7", d_rd1, 8'h00);
        chk8("arst_reg3", d_rd2, 8'h00);
        chk1("arst_busy3", d_bz2, 1'b0);
        chk8("arst_reg0_nozero", z_rd1, 8'h00);
        rd_addr1 = 3'd1; rd_addr2 = 3'd5;
        #1;
        chk8("arst_reg1", d_rd1, 8'h00);
        chk8("arst_reg5_nb", b_rd2, 8'h00);
        rd_addr2 = 3'd0;
        #1;
        chk1("arst_busy0_nozero", z_bz2, 1'b0);
        rst_n = 1'b1;
        rd_addr1 = 3'd7;
        at_edge();
        chk8("post_rst_reg7", d_rd1, 8'h00);
        chk1("post_rst_conflict", d_cf, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 8, width of each register in bits.
REQ-002 Parameter NUM_REGS, default 8, register count; power of two and at least 2; AW = clog2(NUM_REGS).
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to the read ports.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Ports rd_addr1 and rd_addr2, input, AW each, read port addresses.
REQ-008 Ports rd_data1 and rd_data2, output, DATA_W each, read port data.
REQ-009 Ports rd_busy1 and rd_busy2, output, 1 each, the addressed register has a pending write.
REQ-010 Ports we_a, wr_addr_a and wr_data_a: input, widths 1/AW/DATA_W; ALU write port.
REQ-011 Ports we_b, wr_addr_b and wr_data_b: input, widths 1/AW/DATA_W; immediate/load write port.
REQ-012 Ports issue_valid and issue_addr: input, widths 1/AW; marks a destination register busy.
REQ-013 Port wr_conflict, output, 1, registered pulse flagging a same-address dual write.

Function
REQ-014 Reads shall be combinational from the register array, with zero-cycle latency.
REQ-015 Writes shall commit at the rising edge of clk when the port's write enable is high.
REQ-016 When we_a and we_b target the same address in one cycle, port b's data shall be stored.
REQ-017 That same-address dual write shall drive wr_conflict high for exactly the following cycle.
REQ-018 When ZERO_REG=1, reads of address 0 shall return 0.
REQ-019 When ZERO_REG=1, writes and issues to address 0 shall be ignored and rd_busy for address 0 shall be 0.
REQ-020 When BYPASS=1 and a write enable matches a read address in the same cycle, rd_data shall show that write data.
REQ-021 If both write ports match the read address, the bypassed data shall come from port b.
REQ-022 When BYPASS=0, rd_data shall show the stored value until the edge after the write.
REQ-023 Busy vector, one bit per register: issue_valid sets the bit for issue_addr at the rising edge.
REQ-024 A write by either port to an address shall clear its busy bit at the rising edge.
REQ-025 When an issue and a write hit the same address in one cycle, the bit shall end set (set wins).
REQ-026 rd_busyN = busy[rd_addrN], masked to 0 when BYPASS=1 and a same-cycle write to rd_addrN occurs without a same-cycle issue to that address.
REQ-027 Issuing an already-busy register shall leave it busy, with no error and no other side effect.
REQ-028 Address arithmetic shall be unsigned AW-bit, and every address in 0..NUM_REGS-1 shall be legal.

Reset
REQ-029 While rst_n is low, all registers, all busy bits and wr_conflict shall be 0, independent of clk.
REQ-030 While rst_n is low, rd_data shall follow the cleared array and bypass data shall still be forwarded per REQ-020.
REQ-031 Writes and issues presented while rst_n is low shall be discarded.
REQ-032 The first write shall commit on the first rising edge after rst_n rises.

Structure
REQ-033 Shared package regfile_pkg shall hold the defaults REGFILE_DW=8 and REGFILE_NREGS=8 and the write-port priority constant.
REQ-034 The busy-vector logic (set, clear, set-wins rule) shall be a sub-module named regfile_scoreboard.
REQ-035 The storage array and the bypass multiplexers shall remain in regfile_sb.

Verification
REQ-036 Default parameters: we_a=1, addr 1, data 55; next cycle we_b=1, addr 2, data AA; then rd_addr1=1, rd_addr2=2 -> rd_data1=55, rd_data2=AA.
REQ-037 we_a=1, addr 0, data FF with ZERO_REG=1 -> rd_data1 at addr 0 reads 00; rebuilt with ZERO_REG=0 -> reads FF after the edge.
REQ-038 we_a=1 (addr 3, data 11) and we_b=1 (addr 3, data 22) together -> register 3 = 22 and wr_conflict=1 for one cycle, then 0.
REQ-039 BYPASS=1, rd_addr1=4, we_a=1 (addr 4, data 3C) -> rd_data1=3C in the same cycle; BYPASS=0 -> old value, then 3C after the edge.
REQ-040 issue_valid for addr 5 -> rd_busy1=1 at addr 5; issue addr 5 plus write addr 5 in one cycle -> still busy; lone write addr 5 -> busy 0.
REQ-041 Fill registers 1..7, then pulse rst_n low for 3 ns between edges -> all reads 00 and all busy bits 0 immediately.
